// File: rtl/rd_serial_receiver.sv
// RD two-lane serial link receiver: synchronizes the source lines, deframes
// 13-bit odd-parity frames and presents paired words with transfer status.
module rd_serial_receiver #(
    parameter int unsigned MAX_WORDS = 2048
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        xfr_clk_i,
    input  logic        enable_xfr_i,
    input  logic        serial_in0_i,
    input  logic        serial_in1_i,
    output logic        word_valid_o,
    output logic [11:0] data0_o,
    output logic [11:0] data1_o,
    output logic        perr0_o,
    output logic        perr1_o,
    output logic [15:0] word_count_o,
    output logic [15:0] perr_count_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o
);

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BCNT_W = 4;
    localparam int unsigned NSYNC  = 4;
    localparam int unsigned XCLK   = 0;
    localparam int unsigned ENX    = 1;
    localparam int unsigned SER0   = 2;
    localparam int unsigned SER1   = 3;
    localparam logic [BCNT_W-1:0] PAR_POS = BCNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DUMMY,
        ST_SHIFT,
        ST_ENDING
    } state_e;

    // Synchronizers and registered edge events
    logic [NSYNC-1:0] sync1_q;
    logic [NSYNC-1:0] sync2_q;
    logic             xclk_dly_q;
    logic             enx_dly_q;
    logic             sample_q;
    logic             rise_q;
    logic             fall_q;
    logic [1:0]       bit_q;

    // Deframer and output state
    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   sh0_q, sh0_d;
    logic [DATA_W-1:0]   sh1_q, sh1_d;
    logic [1:0]          par_q, par_d;
    logic                word_valid_q, word_valid_d;
    logic [DATA_W-1:0]   data0_q, data0_d;
    logic [DATA_W-1:0]   data1_q, data1_d;
    logic                perr0_q, perr0_d;
    logic                perr1_q, perr1_d;
    logic [CNT_W-1:0]    wc_q, wc_d;
    logic [CNT_W-1:0]    pc_q, pc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [1:0]          frame_perr;
    logic                frame_end;

    // All four lines share one synchronizer depth so they stay aligned.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            xclk_dly_q <= 1'b0;
            enx_dly_q  <= 1'b0;
            sample_q   <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            bit_q      <= '0;
        end else begin
            sync1_q    <= {serial_in1_i, serial_in0_i, enable_xfr_i, xfr_clk_i};
            sync2_q    <= sync1_q;
            xclk_dly_q <= sync2_q[XCLK];
            enx_dly_q  <= sync2_q[ENX];
            sample_q   <= sync2_q[XCLK] & ~xclk_dly_q;
            rise_q     <= sync2_q[ENX] & ~enx_dly_q;
            fall_q     <= ~sync2_q[ENX] & enx_dly_q;
            bit_q      <= sync2_q[SER1:SER0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= '0;
            sh0_q        <= '0;
            sh1_q        <= '0;
            par_q        <= '0;
            word_valid_q <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            perr0_q      <= 1'b0;
            perr1_q      <= 1'b0;
            wc_q         <= '0;
            pc_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            sh0_q        <= sh0_d;
            sh1_q        <= sh1_d;
            par_q        <= par_d;
            word_valid_q <= word_valid_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            perr0_q      <= perr0_d;
            perr1_q      <= perr1_d;
            wc_q         <= wc_d;
            pc_q         <= pc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    // Odd parity: a lane fails when its 13 bits hold an even number of ones.
    assign frame_perr = ~(par_q ^ bit_q);

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        sh0_d        = sh0_q;
        sh1_d        = sh1_q;
        par_d        = par_q;
        word_valid_d = 1'b0;
        data0_d      = data0_q;
        data1_d      = data1_q;
        perr0_d      = perr0_q;
        perr1_d      = perr1_q;
        wc_d         = wc_q;
        pc_d         = pc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        frame_end    = 1'b0;

        if (!enable_i) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise_q) begin
                        wc_d     = '0;
                        pc_d     = '0;
                        ovf_d    = 1'b0;
                        busy_d   = 1'b1;
                        bitcnt_d = '0;
                        par_d    = '0;
                        state_d  = ST_DUMMY;
                    end
                end
                ST_DUMMY: begin
                    // First sample carries idle line state and is discarded.
                    if (fall_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_ARMED;
                    end else if (sample_q) begin
                        bitcnt_d = '0;
                        par_d    = '0;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sample_q) begin
                        if (bitcnt_q != PAR_POS) begin
                            sh0_d    = {sh0_q[DATA_W-2:0], bit_q[0]};
                            sh1_d    = {sh1_q[DATA_W-2:0], bit_q[1]};
                            par_d    = par_q ^ bit_q;
                            bitcnt_d = bitcnt_q + BCNT_W'(1);
                        end else begin
                            frame_end = 1'b1;
                            if (32'(wc_q) < MAX_WORDS) begin
                                word_valid_d = 1'b1;
                                data0_d      = sh0_q;
                                data1_d      = sh1_q;
                                perr0_d      = frame_perr[0];
                                perr1_d      = frame_perr[1];
                                wc_d         = wc_q + CNT_W'(1);
                                if ((|frame_perr) && (pc_q != CNT_MAX)) begin
                                    pc_d = pc_q + CNT_W'(1);
                                end
                            end else begin
                                ovf_d = 1'b1;
                            end
                            bitcnt_d = '0;
                            par_d    = '0;
                        end
                    end
                    // A completing frame is delivered before the end of transfer.
                    if (fall_q) begin
                        if (frame_end) begin
                            state_d = ST_ENDING;
                        end else begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_ARMED;
                        end
                    end
                end
                ST_ENDING: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_ARMED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign word_valid_o = word_valid_q;
    assign data0_o      = data0_q;
    assign data1_o      = data1_q;
    assign perr0_o      = perr0_q;
    assign perr1_o      = perr1_q;
    assign word_count_o = wc_q;
    assign perr_count_o = pc_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;

endmodule
